// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending input conditioner.
package vend_pkg;
  typedef enum logic [2:0] {C_IDLE, C_MEASURE, C_ACCEPT, C_REJECT, C_JAM} coin_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_COIN_MIN_CYCLES = 3;
  localparam int DEF_COIN_MAX_CYCLES = 20;
endpackage

// File: rtl/vend_debounce_edge.sv
// One button lane: 2-flop sync, debounce counter, gated rising-edge pulse.
module vend_debounce_edge
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic en,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2, db, db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      db_q  <= db;
      // edge seen while en is low is dropped, never deferred
      pulse <= db & ~db_q & en;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vend_input_conditioner.sv
// Coin width validation FSM plus two debounced button lanes with coin lockout.
module vend_input_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COIN_MIN_CYCLES = DEF_COIN_MIN_CYCLES,
  parameter int COIN_MAX_CYCLES = DEF_COIN_MAX_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic coin_raw,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic quarter_in,
  output logic select1,
  output logic select2,
  output logic coin_reject,
  output logic coin_jam
);
  localparam int NUM_BTN = 2;
  localparam int CW      = $clog2(COIN_MAX_CYCLES + 1);
  localparam int JW      = $clog2(DEBOUNCE_CYCLES + 1);

  logic              coin_s1, coin_s2;
  coin_state_t       state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [JW-1:0]     jcnt, jcnt_nx;
  logic [NUM_BTN-1:0] btn_raw_v, sel_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      coin_s1     <= 1'b0;
      coin_s2     <= 1'b0;
      state       <= C_IDLE;
      cnt         <= '0;
      jcnt        <= '0;
      quarter_in  <= 1'b0;
      coin_reject <= 1'b0;
      coin_jam    <= 1'b0;
    end else begin
      coin_s1     <= coin_raw;
      coin_s2     <= coin_s1;
      state       <= state_nx;
      cnt         <= cnt_nx;
      jcnt        <= jcnt_nx;
      // decoded from next state so outputs track the state register exactly
      quarter_in  <= (state_nx == C_ACCEPT);
      coin_reject <= (state_nx == C_REJECT);
      coin_jam    <= (state_nx == C_JAM);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    jcnt_nx  = jcnt;
    case (state)
      C_IDLE: if (coin_s2) begin
        state_nx = C_MEASURE;
        cnt_nx   = CW'(1);
      end
      C_MEASURE: begin
        if (coin_s2) begin
          if (cnt + 1'b1 == CW'(COIN_MAX_CYCLES)) begin
            state_nx = C_JAM;
            jcnt_nx  = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else if (cnt >= CW'(COIN_MIN_CYCLES)) begin
          state_nx = C_ACCEPT;
        end else begin
          state_nx = C_REJECT;
        end
      end
      C_ACCEPT, C_REJECT: begin
        state_nx = C_IDLE;
        cnt_nx   = '0;
      end
      C_JAM: begin
        // leave only after a clean run of low samples
        if (coin_s2) begin
          jcnt_nx = '0;
        end else if (jcnt == JW'(DEBOUNCE_CYCLES - 1)) begin
          state_nx = C_IDLE;
          jcnt_nx  = '0;
          cnt_nx   = '0;
        end else begin
          jcnt_nx = jcnt + 1'b1;
        end
      end
      default: state_nx = C_IDLE;
    endcase
  end

  assign btn_raw_v = {btn2_raw, btn1_raw};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    vend_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw_v[i]),
      .en    (state == C_IDLE),
      .pulse (sel_v[i])
    );
  end

  assign select1 = sel_v[0];
  assign select2 = sel_v[1];
endmodule

// File: tb/tb_vend_input_conditioner.sv
// Scoreboard bench: scenario planner predicts output events, negedge monitor matches them.
module tb_vend_input_conditioner;
  localparam int D    = 4;
  localparam int CMIN = 3;
  localparam int CMAX = 20;
  localparam int L    = 80;

  localparam int K_Q = 0, K_REJ = 1, K_S1 = 2, K_S2 = 3, K_JR = 4, K_JF = 5;

  typedef struct {
    int kind;
    int cyc;
  } evt_t;

  logic clk = 1'b0, reset = 1'b1;
  logic coin_raw = 1'b0, btn1_raw = 1'b0, btn2_raw = 1'b0;
  logic quarter_in, select1, select2, coin_reject, coin_jam;

  int   cyc = 0;
  int   n_checks = 0, n_pass = 0;
  evt_t exp_q[$];
  logic jam_prev = 1'b0;

  vend_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .COIN_MIN_CYCLES(CMIN), .COIN_MAX_CYCLES(CMAX)
  ) dut (
    .clk(clk), .reset(reset), .coin_raw(coin_raw), .btn1_raw(btn1_raw),
    .btn2_raw(btn2_raw), .quarter_in(quarter_in), .select1(select1),
    .select2(select2), .coin_reject(coin_reject), .coin_jam(coin_jam)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_Q:     return "quarter_in";
      K_REJ:   return "coin_reject";
      K_S1:    return "select1";
      K_S2:    return "select2";
      K_JR:    return "coin_jam_rise";
      default: return "coin_jam_fall";
    endcase
  endfunction

  task automatic expect_evt(input int kind, input int at);
    evt_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int at);
    int idx = -1;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == kind) idx = i;
    n_checks++;
    if (idx < 0) begin
      $display("FAIL %s: unexpected pulse at cycle %0d, required none", kname(kind), at);
    end else begin
      if (exp_q[idx].cyc == at) n_pass++;
      else $display("FAIL %s: seen at cycle %0d, required cycle %0d", kname(kind), at, exp_q[idx].cyc);
      exp_q.delete(idx);
    end
  endtask

  // Monitor: every observed output event must match a predicted one.
  always @(negedge clk) begin
    if (quarter_in === 1'b1)  observe(K_Q, cyc);
    if (coin_reject === 1'b1) observe(K_REJ, cyc);
    if (select1 === 1'b1)     observe(K_S1, cyc);
    if (select2 === 1'b1)     observe(K_S2, cyc);
    if ((coin_jam === 1'b1) && !jam_prev) observe(K_JR, cyc);
    if ((coin_jam !== 1'b1) && jam_prev)  observe(K_JF, cyc);
    jam_prev <= (coin_jam === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b, required %b", name, got, want);
  endtask

  task automatic drain_check(input string name);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      foreach (exp_q[i])
        $display("FAIL %s: %s missing, required at cycle %0d", name, kname(exp_q[i].kind), exp_q[i].cyc);
      exp_q.delete();
    end
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_quarter_in"}, quarter_in, 1'b0);
    chk({tag, "_coin_reject"}, coin_reject, 1'b0);
    chk({tag, "_coin_jam"}, coin_jam, 1'b0);
    chk({tag, "_select1"}, select1, 1'b0);
    chk({tag, "_select2"}, select2, 1'b0);
  endtask

  // w: coin width (0 = none), coff: coin start; bmask: buttons pressed;
  // boff: first bounce, nb: one-cycle bounce glitches, hold: clean hold length.
  task automatic run_scn(input string name, input int w, input int coff, input int bmask,
                         input int boff, input int nb, input int hold);
    int  base     = cyc;
    int  c0       = base + coff + 1;
    int  bstart   = boff + 2 * nb;
    int  b0       = base + bstart + 1;
    int  busy_end = 0;
    int  rise;
    bit  bh;
    if (w > 0) begin
      if (w < CMIN) begin
        expect_evt(K_REJ, c0 + w + 2);
        busy_end = c0 + w + 2;
      end else if (w < CMAX) begin
        expect_evt(K_Q, c0 + w + 2);
        busy_end = c0 + w + 2;
      end else begin
        expect_evt(K_JR, c0 + CMAX + 1);
        expect_evt(K_JF, c0 + w + D + 1);
        busy_end = c0 + w + D;
      end
    end
    if (bmask != 0 && hold >= D) begin
      rise = b0 + D + 1;
      if (!(w > 0 && rise >= c0 + 2 && rise <= busy_end)) begin
        if (bmask & 1) expect_evt(K_S1, rise + 1);
        if (bmask & 2) expect_evt(K_S2, rise + 1);
      end
    end
    for (int t = 0; t < L; t++) begin
      coin_raw = (w > 0 && t >= coff && t < coff + w);
      bh = (t >= bstart && t < bstart + hold) ||
           (t >= boff && t < bstart && ((t - boff) % 2 == 0));
      btn1_raw = ((bmask & 1) != 0) && bh;
      btn2_raw = ((bmask & 2) != 0) && bh;
      tick();
    end
    drain_check(name);
  endtask

  initial begin
    int base;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    zero_outputs("reset");

    run_scn("coin_w5", 5, 0, 0, 0, 0, 0);
    run_scn("coin_w2_short", 2, 0, 0, 0, 0, 0);
    run_scn("coin_w30_jam", 30, 0, 0, 0, 0, 0);
    run_scn("coin_w3_min", 3, 0, 0, 0, 0, 0);
    run_scn("coin_w19_max_ok", 19, 0, 0, 0, 0, 0);
    run_scn("coin_w20_jam", 20, 0, 0, 0, 0, 0);
    run_scn("btn1_bounce", 0, 0, 1, 0, 2, 12);
    run_scn("btn2_lockout", 6, 0, 2, 1, 0, 10);
    run_scn("btn2_repress", 0, 0, 2, 0, 0, 8);
    run_scn("both_btns", 0, 0, 3, 0, 0, 6);
    run_scn("btn_hold_eq_d", 0, 0, 1, 0, 0, D);
    run_scn("btn_hold_short", 0, 0, 1, 0, 0, D - 1);

    // reset while measuring (cnt=4) with btn1 held through reset release
    base = cyc;
    coin_raw = 1'b1;
    btn1_raw = 1'b1;
    repeat (6) tick();
    reset    = 1'b1;
    coin_raw = 1'b0;
    tick();
    reset = 1'b0;
    expect_evt(K_S1, base + 14);
    @(negedge clk);
    zero_outputs("post_reset");
    repeat (12) tick();
    btn1_raw = 1'b0;
    repeat (30) tick();
    drain_check("reset_measure");

    for (int n = 0; n < 40; n++) begin
      int w, coff, bmask, boff, nb, hold;
      w     = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 26));
      coff  = $urandom_range(0, 10);
      bmask = (w == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      boff  = $urandom_range(0, 10);
      nb    = $urandom_range(0, 3);
      hold  = $urandom_range(1, 14);
      run_scn("random", w, coff, bmask, boff, nb, hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
